// File: rtl/cpu_pkg.sv
// Shared pipeline-control definitions: hazard FSM encoding, forwarding selects,
// register-number width and the register-match helper used by the forwarding logic.
package cpu_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        LDSTALL = 2'b01,
        MWAIT   = 2'b10
    } hz_state_e;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_REG    = 2'b00;
    localparam fwd_sel_t FWD_EXALU  = 2'b01;
    localparam fwd_sel_t FWD_MEMALU = 2'b10;
    localparam fwd_sel_t FWD_MEMLD  = 2'b11;

    // $0 is hard-wired, so a write to it can never satisfy a read.
    function automatic logic reg_match(input logic wr,
                                       input logic [REG_W-1:0] dst,
                                       input logic [REG_W-1:0] src);
        return wr && (dst != '0) && (dst == src);
    endfunction

endpackage

// File: rtl/pipe_fwd_unit.sv
// Combinational forwarding comparator for one EX operand; the younger EX result
// wins over the MEM result, and an EX-stage load cannot forward yet.
module pipe_fwd_unit
    import cpu_pkg::*;
(
    input  logic [REG_W-1:0] src,
    input  logic [REG_W-1:0] ern,
    input  logic             ewreg,
    input  logic             em2reg,
    input  logic [REG_W-1:0] mrn,
    input  logic             mwreg,
    input  logic             mm2reg,
    output logic [1:0]       sel
);

    always_comb begin
        sel = FWD_REG;
        if (reg_match(ewreg, ern, src) && !em2reg) begin
            sel = FWD_EXALU;
        end else if (reg_match(mwreg, mrn, src)) begin
            sel = mm2reg ? FWD_MEMLD : FWD_MEMALU;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: load-use stall, memory-wait
// freeze, branch squash flag, EX forwarding selects and stall statistics.
module pipe_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int MWAIT_MAX = 64
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic             use_rs,
    input  logic             use_rt,
    input  logic [REG_W-1:0] ern,
    input  logic             ewreg,
    input  logic             em2reg,
    input  logic [REG_W-1:0] mrn,
    input  logic             mwreg,
    input  logic             mm2reg,
    input  logic             br_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             cnt_clr,
    output logic             wpc,
    output logic             wpcir,
    output logic             ewinh,
    output logic             freeze,
    output logic             dbubble,
    output logic [1:0]       fwda,
    output logic [1:0]       fwdb,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             mem_err
);

    localparam int             WC_W   = $clog2(MWAIT_MAX + 1);
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(MWAIT_MAX);

    hz_state_e        state_q, state_d;
    logic             dbubble_q, dbubble_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [WC_W-1:0]  wcnt_q, wcnt_d;
    logic             mem_err_q, mem_err_d;

    logic mw, ld_hz_raw, ld_hz, br_eff;

    pipe_fwd_unit u_fwd_a (
        .src(rs), .ern(ern), .ewreg(ewreg), .em2reg(em2reg),
        .mrn(mrn), .mwreg(mwreg), .mm2reg(mm2reg), .sel(fwda)
    );

    pipe_fwd_unit u_fwd_b (
        .src(rt), .ern(ern), .ewreg(ewreg), .em2reg(em2reg),
        .mrn(mrn), .mwreg(mwreg), .mm2reg(mm2reg), .sel(fwdb)
    );

    // A squashed instruction in ID must neither stall nor redirect.
    assign mw        = dmem_req & ~dmem_ready;
    assign ld_hz_raw = ewreg & em2reg & (ern != '0) &
                       ((use_rs & (ern == rs)) | (use_rt & (ern == rt)));
    assign ld_hz     = ld_hz_raw & ~dbubble_q;
    assign br_eff    = br_taken & ~dbubble_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= RUN;
            dbubble_q   <= 1'b0;
            stall_cnt_q <= '0;
            wcnt_q      <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            dbubble_q   <= dbubble_d;
            stall_cnt_q <= stall_cnt_d;
            wcnt_q      <= wcnt_d;
            mem_err_q   <= mem_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (mw) state_d = MWAIT;
                     else if (ld_hz) state_d = LDSTALL;
            LDSTALL: state_d = mw ? MWAIT : RUN;
            MWAIT:   if (!mw) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        wpc    = 1'b1;
        wpcir  = 1'b1;
        ewinh  = 1'b0;
        freeze = 1'b0;
        if (mw) begin
            wpc    = 1'b0;
            wpcir  = 1'b0;
            freeze = 1'b1;
        end else if (ld_hz) begin
            wpc    = 1'b0;
            wpcir  = 1'b0;
            ewinh  = 1'b1;
        end
    end

    // The wait counter covers every cycle spent waiting, including the one
    // in which the wait is first seen, so mem_err follows MWAIT_MAX wait cycles.
    always_comb begin
        dbubble_d   = wpcir ? br_eff : dbubble_q;
        stall_cnt_d = stall_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
        end else if (!wpcir && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        wcnt_d = '0;
        if (state_d == MWAIT) begin
            wcnt_d = (wcnt_q == WC_MAX) ? wcnt_q : wcnt_q + WC_W'(1);
        end
        mem_err_d = mem_err_q;
        if (cnt_clr) begin
            mem_err_d = 1'b0;
        end else if (wcnt_d == WC_MAX) begin
            mem_err_d = 1'b1;
        end
    end

    assign dbubble   = dbubble_q;
    assign stall_cnt = stall_cnt_q;
    assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: expected outputs are queued when each
// cycle's stimulus is driven and compared mid-cycle by a separate checker.
module tb_pipe_hazard_ctrl;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic [4:0] rs, rt, ern, mrn;
    logic       use_rs, use_rt, ewreg, em2reg, mwreg, mm2reg;
    logic       br_taken, dmem_req, dmem_ready, cnt_clr;
    logic       wpc, wpcir, ewinh, freeze, dbubble, mem_err;
    logic [1:0] fwda, fwdb;
    logic [3:0] stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string      tag;
        logic       wpc, wpcir, ewinh, freeze, dbub;
        logic [1:0] fwda, fwdb;
        logic [3:0] scnt;
        logic       merr;
    } exp_t;

    exp_t sb[$];
    exp_t cur;

    pipe_hazard_ctrl #(.CNT_W(4), .MWAIT_MAX(4)) dut (
        .clock(clock), .resetn(resetn),
        .rs(rs), .rt(rt), .use_rs(use_rs), .use_rt(use_rt),
        .ern(ern), .ewreg(ewreg), .em2reg(em2reg),
        .mrn(mrn), .mwreg(mwreg), .mm2reg(mm2reg),
        .br_taken(br_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .cnt_clr(cnt_clr),
        .wpc(wpc), .wpcir(wpcir), .ewinh(ewinh), .freeze(freeze),
        .dbubble(dbubble), .fwda(fwda), .fwdb(fwdb),
        .stall_cnt(stall_cnt), .mem_err(mem_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rs = '0; rt = '0; use_rs = 0; use_rt = 0;
        ern = '0; ewreg = 0; em2reg = 0;
        mrn = '0; mwreg = 0; mm2reg = 0;
        br_taken = 0; dmem_req = 0; dmem_ready = 0; cnt_clr = 0;
    endtask

    task automatic ld_use_r2();
        ern = 5'd2; ewreg = 1; em2reg = 1; rs = 5'd2; use_rs = 1;
    endtask

    task automatic push(input string tag, input logic p_wpc, input logic p_wpcir,
                        input logic p_ewinh, input logic p_freeze, input logic p_dbub,
                        input logic [1:0] p_fwda, input logic [1:0] p_fwdb,
                        input logic [3:0] p_scnt, input logic p_merr);
        exp_t e;
        e.tag = tag; e.wpc = p_wpc; e.wpcir = p_wpcir; e.ewinh = p_ewinh;
        e.freeze = p_freeze; e.dbub = p_dbub; e.fwda = p_fwda; e.fwdb = p_fwdb;
        e.scnt = p_scnt; e.merr = p_merr;
        sb.push_back(e);
    endtask

    // Outputs are sampled 2 time units after the falling edge, once the
    // stimulus driven at that edge has settled.
    always @(negedge clock) begin
        #2;
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            chk({cur.tag, ".wpc"},       16'(wpc),       16'(cur.wpc));
            chk({cur.tag, ".wpcir"},     16'(wpcir),     16'(cur.wpcir));
            chk({cur.tag, ".ewinh"},     16'(ewinh),     16'(cur.ewinh));
            chk({cur.tag, ".freeze"},    16'(freeze),    16'(cur.freeze));
            chk({cur.tag, ".dbubble"},   16'(dbubble),   16'(cur.dbub));
            chk({cur.tag, ".fwda"},      16'(fwda),      16'(cur.fwda));
            chk({cur.tag, ".fwdb"},      16'(fwdb),      16'(cur.fwdb));
            chk({cur.tag, ".stall_cnt"}, 16'(stall_cnt), 16'(cur.scnt));
            chk({cur.tag, ".mem_err"},   16'(mem_err),   16'(cur.merr));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        @(negedge clock);
        push("reset", 1, 1, 0, 0, 0, 2'd0, 2'd0, 4'd0, 0);

        @(negedge clock); resetn = 1; idle(); ld_use_r2(); rt = 5'd5; use_rt = 1;
        push("lduse", 0, 0, 1, 0, 0, 2'd0, 2'd0, 4'd0, 0);
        @(negedge clock); idle(); mrn = 5'd2; mwreg = 1; mm2reg = 1;
        rs = 5'd2; use_rs = 1; rt = 5'd5; use_rt = 1;
        push("lduse_fwd", 1, 1, 0, 0, 0, 2'd3, 2'd0, 4'd1, 0);

        @(negedge clock); idle(); ern = 5'd3; ewreg = 1; mrn = 5'd3; mwreg = 1;
        rs = 5'd3; use_rs = 1; rt = 5'd7;
        push("fwd_ex_prio", 1, 1, 0, 0, 0, 2'd1, 2'd0, 4'd1, 0);
        @(negedge clock); idle(); ern = 5'd0; ewreg = 1; em2reg = 1; mrn = 5'd0; mwreg = 1;
        use_rs = 1; use_rt = 1;
        push("fwd_r0", 1, 1, 0, 0, 0, 2'd0, 2'd0, 4'd1, 0);
        @(negedge clock); idle(); ern = 5'd4; ewreg = 1; mrn = 5'd6; mwreg = 1;
        rs = 5'd4; rt = 5'd6;
        push("fwd_mix", 1, 1, 0, 0, 0, 2'd1, 2'd2, 4'd1, 0);
        @(negedge clock); idle(); ern = 5'd9; ewreg = 1; mrn = 5'd9; mwreg = 1; mm2reg = 1;
        rs = 5'd1; rt = 5'd9;
        push("fwd_b_ex", 1, 1, 0, 0, 0, 2'd0, 2'd1, 4'd1, 0);

        @(negedge clock); idle(); br_taken = 1;
        push("br", 1, 1, 0, 0, 0, 2'd0, 2'd0, 4'd1, 0);
        @(negedge clock); idle(); br_taken = 1; ld_use_r2();
        push("br_masked", 1, 1, 0, 0, 1, 2'd0, 2'd0, 4'd1, 0);
        @(negedge clock); idle();
        push("br_clr", 1, 1, 0, 0, 0, 2'd0, 2'd0, 4'd1, 0);
        @(negedge clock); idle(); br_taken = 1; ld_use_r2();
        push("br_ld", 0, 0, 1, 0, 0, 2'd0, 2'd0, 4'd1, 0);
        @(negedge clock); idle(); br_taken = 1;
        push("br_after_ld", 1, 1, 0, 0, 0, 2'd0, 2'd0, 4'd2, 0);
        @(negedge clock); idle(); dmem_req = 1;
        push("dbub_mw", 0, 0, 0, 1, 1, 2'd0, 2'd0, 4'd2, 0);
        @(negedge clock); idle();
        push("dbub_held", 1, 1, 0, 0, 1, 2'd0, 2'd0, 4'd3, 0);
        @(negedge clock); idle(); cnt_clr = 1;
        push("clr", 1, 1, 0, 0, 0, 2'd0, 2'd0, 4'd3, 0);

        for (int i = 0; i < 3; i++) begin
            @(negedge clock); idle(); dmem_req = 1; ld_use_r2();
            push("mw_ld", 0, 0, 0, 1, 0, 2'd0, 2'd0, 4'(i), 0);
        end
        @(negedge clock); idle(); dmem_req = 1; dmem_ready = 1; ld_use_r2();
        push("ready_ld", 0, 0, 1, 0, 0, 2'd0, 2'd0, 4'd3, 0);
        @(negedge clock); idle(); mrn = 5'd2; mwreg = 1; mm2reg = 1; rs = 5'd2; use_rs = 1;
        push("after_ld", 1, 1, 0, 0, 0, 2'd3, 2'd0, 4'd4, 0);

        for (int i = 0; i < 6; i++) begin
            @(negedge clock); idle(); dmem_req = 1;
            push("timeout", 0, 0, 0, 1, 0, 2'd0, 2'd0, 4'(4 + i), (i >= 4));
        end
        @(negedge clock); idle(); dmem_req = 1; dmem_ready = 1;
        push("timeout_ready", 1, 1, 0, 0, 0, 2'd0, 2'd0, 4'd10, 1);
        @(negedge clock); idle(); cnt_clr = 1; br_taken = 1;
        push("clr_err", 1, 1, 0, 0, 0, 2'd0, 2'd0, 4'd10, 1);

        for (int i = 0; i < 18; i++) begin
            @(negedge clock); idle(); dmem_req = 1;
            push("sat", 0, 0, 0, 1, 1, 2'd0, 2'd0, (i > 15) ? 4'd15 : 4'(i), (i >= 4));
        end
        #3 resetn = 0;
        #1;
        chk("arst.dbubble",   16'(dbubble),   16'd0);
        chk("arst.stall_cnt", 16'(stall_cnt), 16'd0);
        chk("arst.mem_err",   16'(mem_err),   16'd0);
        chk("arst.freeze",    16'(freeze),    16'd1);
        dmem_req = 0;
        #1;
        chk("arst.wpc",    16'(wpc),    16'd1);
        chk("arst.wpcir",  16'(wpcir),  16'd1);
        chk("arst.freeze_idle", 16'(freeze), 16'd0);

        @(negedge clock); resetn = 1; idle();
        push("post_rst", 1, 1, 0, 0, 0, 2'd0, 2'd0, 4'd0, 0);
        @(negedge clock); idle();
        push("post_rst2", 1, 1, 0, 0, 0, 2'd0, 2'd0, 4'd0, 0);

        repeat (3) @(negedge clock);
        #4;
        chk("sb_drain", 16'(sb.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
